// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I requests into instruction words behind a single output register stage.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7b5,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_pulse,
    output logic [7:0]  err_count
);
    logic [31:0] word, cnt;
    logic        ok, acc, fit12, fit13, fit21, shift;
    // Sign-extension checks: the bits above the field must all match its sign bit.
    assign fit12 = &in_imm[31:11] | ~|in_imm[31:11];
    assign fit13 = &in_imm[31:12] | ~|in_imm[31:12];
    assign fit21 = &in_imm[31:20] | ~|in_imm[31:20];
    assign shift = in_funct3[1:0] == 2'b01;
    assign in_ready = reset || !out_valid || out_ready;
    assign acc = in_valid && in_ready && !reset;

    always_comb begin
        word = '0;
        ok   = 1'b0;
        case (in_kind)
            3'd0: begin
                ok   = fit12;
                word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            end
            3'd1: begin
                ok   = fit12;
                word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            end
            3'd2: begin
                ok   = 1'b1;
                word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            end
            3'd3: begin
                ok   = fit13 && !in_imm[0];
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011};
            end
            3'd4: begin
                ok   = shift ? ~|in_imm[31:5] : fit12;
                word = shift ? {1'b0, in_funct3[2] & in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011}
                             : {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            end
            3'd5: begin
                ok   = fit21 && !in_imm[0];
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            end
            default: begin
                ok   = 1'b0;
                word = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            cnt       <= BASE_ADDR;
        end else begin
            err_pulse <= acc && !ok;
            if (acc && ok) begin
                out_valid <= 1'b1;
                out_instr <= word;
                out_addr  <= cnt;
                cnt       <= cnt + 32'd4;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (acc && !ok && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against an arithmetic reference model.
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'h0000_1000;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_funct7b5, out_valid, out_ready, err_pulse;
    logic [2:0]  in_kind, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic [7:0]  err_count;
    int          tests = 0, fails = 0;
    logic        m_valid = 1'b0, m_err = 1'b0;
    logic [31:0] m_instr = '0, m_addr = '0, m_cnt = BASE;
    int          m_ecnt = 0;

    instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(logic [31:0] u, int hi, int lo);
        return (u >> lo) % (32'd1 << (hi - lo + 1));
    endfunction

    // Reference encoder: builds the word as a sum of shifted fields and checks ranges numerically.
    function automatic logic [31:0] ref_enc(int kind, int f3, int f7, int rd, int rs1, int rs2, int imm, output bit ok);
        logic [31:0] u = imm;
        logic [31:0] r = rd * 128, a = rs1 * 32768, b = rs2 * 1048576;
        ok = 0;
        case (kind)
            0: begin
                ok = imm >= -2048 && imm <= 2047;
                return fld(u, 11, 0) * 1048576 + a + 2 * 4096 + r + 3;
            end
            1: begin
                ok = imm >= -2048 && imm <= 2047;
                return fld(u, 11, 5) * 33554432 + b + a + 2 * 4096 + fld(u, 4, 0) * 128 + 35;
            end
            2: begin
                ok = 1;
                return f7 * 1073741824 + b + a + f3 * 4096 + r + 51;
            end
            3: begin
                ok = imm >= -4096 && imm <= 4094 && imm % 2 == 0;
                return fld(u, 12, 12) * 32'h8000_0000 + fld(u, 10, 5) * 33554432 + b + a
                       + fld(u, 4, 1) * 256 + fld(u, 11, 11) * 128 + 99;
            end
            4: begin
                if (f3 == 1 || f3 == 5) begin
                    ok = imm >= 0 && imm <= 31;
                    return (f3 == 5 ? f7 : 0) * 1073741824 + fld(u, 4, 0) * 1048576 + a + f3 * 4096 + r + 19;
                end
                ok = imm >= -2048 && imm <= 2047;
                return fld(u, 11, 0) * 1048576 + a + f3 * 4096 + r + 19;
            end
            5: begin
                ok = imm >= -1048576 && imm <= 1048574 && imm % 2 == 0;
                return fld(u, 20, 20) * 32'h8000_0000 + fld(u, 10, 1) * 2097152 + fld(u, 11, 11) * 1048576
                       + fld(u, 19, 12) * 4096 + r + 111;
            end
            default: return 0;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check in_ready, advance the model at posedge, check outputs at next negedge.
    task automatic cyc(input logic rst, input logic v, input int kind, input int f3, input int f7,
                       input int rd, input int rs1, input int rs2, input int imm, input logic ordy);
        bit          ok;
        logic [31:0] w;
        logic        acc;
        reset = rst; in_valid = v; in_kind = 3'(kind); in_funct3 = 3'(f3); in_funct7b5 = f7[0];
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm; out_ready = ordy;
        #1;
        check("in_ready", in_ready, rst || !m_valid || ordy);
        w   = ref_enc(kind, f3, f7, rd, rs1, rs2, imm, ok);
        acc = !rst && v && (!m_valid || ordy);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_err = 0; m_ecnt = 0; m_cnt = BASE; m_instr = 0; m_addr = 0;
        end else begin
            m_err = acc && !ok;
            if (acc && ok) begin
                m_valid = 1; m_instr = w; m_addr = m_cnt; m_cnt = m_cnt + 4;
            end else if (ordy) m_valid = 0;
            if (acc && !ok && m_ecnt < 255) m_ecnt++;
        end
        @(negedge clk);
        check("out_valid", out_valid, m_valid);
        check("err_pulse", err_pulse, m_err);
        check("err_count", err_count, m_ecnt);
        if (m_valid) begin
            check("out_instr", out_instr, m_instr);
            check("out_addr", out_addr, m_addr);
        end
    endtask

    int bl[] = '{-2049, -2048, 2047, 2048, -1, 0, 31, 32, -4097, -4096, 4094, 4095, 4096,
                 -1048577, -1048576, 1048574, 1048575, 1048576, 3, -3};

    initial begin
        int imm;
        @(negedge clk);
        cyc(1, 1, 0, 0, 0, 1, 1, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_instr", out_instr, 0);
        check("rst_addr", out_addr, 0);
        cyc(0, 1, 0, 0, 0, 5, 2, 0, 8, 1);
        check("lw_word", out_instr, 32'h0081_2283);
        check("lw_addr", out_addr, BASE);
        cyc(0, 1, 2, 0, 0, 3, 1, 2, 0, 1);
        check("add_word", out_instr, 32'h0020_81B3);
        check("add_addr", out_addr, BASE + 4);
        cyc(0, 1, 2, 0, 1, 3, 1, 2, 0, 1);
        check("sub_word", out_instr, 32'h4020_81B3);
        check("sub_addr", out_addr, BASE + 8);
        cyc(0, 1, 3, 0, 0, 9, 1, 2, -4, 1);
        check("beq_word", out_instr, 32'hFE20_8EE3);
        cyc(0, 1, 5, 0, 0, 1, 0, 0, 8, 1);
        check("jal_word", out_instr, 32'h0080_00EF);
        cyc(0, 1, 4, 0, 0, 1, 1, 0, 2048, 1);
        check("addi_err", err_pulse, 1);
        check("addi_noval", out_valid, 0);
        check("addi_cnt", err_count, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("err_once", err_pulse, 0);
        cyc(0, 1, 0, 0, 0, 5, 2, 0, 8, 1);
        check("after_err_addr", out_addr, BASE + 20);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 2, 0, 0, 4, 5, 6, 0, 0);
        cyc(0, 1, 2, 7, 1, 8, 9, 10, 0, 0);
        check("bp_ready", in_ready, 0);
        check("bp_hold", out_addr, BASE + 24);
        cyc(0, 1, 2, 7, 1, 8, 9, 10, 0, 0);
        cyc(0, 1, 2, 7, 1, 8, 9, 10, 0, 1);
        check("bp_second", out_addr, BASE + 28);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_drop", out_valid, 0);
        cyc(0, 1, 0, 0, 0, 5, 2, 0, 8, 1);
        check("rst_base", out_addr, BASE);
        for (int i = 0; i < 260; i++) cyc(0, 1, 6 + (i % 2), 0, 0, 0, 0, 0, 0, 1);
        check("err_sat", err_count, 255);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: imm = int'($urandom_range(0, 63)) - 32;
                1: imm = bl[$urandom_range(0, bl.size() - 1)];
                2: imm = int'($urandom_range(0, 8191)) - 4096;
                default: imm = int'($urandom);
            endcase
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm, $urandom_range(0, 3) != 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address given to the first emitted instruction.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  request accepted on the cycle where in_valid && in_ready.
REQ-006 in_kind  in  3  0=lw, 1=sw, 2=R-type, 3=beq, 4=I-type ALU, 5=jal, 6/7=illegal.
REQ-007 in_funct3  in  3  funct3 for R-type/I-type; ignored otherwise.
REQ-008 in_funct7b5  in  1  instruction bit 30 for R-type and I-type shifts.
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-010 in_imm  in  32  signed byte immediate/offset.
REQ-011 out_valid  out  1  encoded word available.
REQ-012 out_ready  in  1  consumer takes the word when out_valid && out_ready.
REQ-013 out_instr  out  32  RV32I instruction word.
REQ-014 out_addr  out  32  byte address of out_instr.
REQ-015 err_pulse  out  1  one-cycle flag: accepted request was unencodable.
REQ-016 err_count  out  8  saturating count of rejected requests.

Function
REQ-017 Opcodes SHALL be lw 0000011, sw 0100011, R 0110011, beq 1100011, I 0010011, jal 1101111.
REQ-018 lw/sw SHALL use funct3 010; beq SHALL use funct3 000; R and I SHALL use in_funct3.
REQ-019 Formats SHALL be the standard RV32I I/S/B/R/J layouts; R-type bit 30 = in_funct7b5, bits 31,29:25 = 0.
REQ-020 I-type funct3 001/101 (shifts): bits 24:20 = in_imm[4:0], bit 30 = in_funct7b5 (only for 101), other bits 31:25 = 0.
REQ-021 Range checks: lw/sw/I non-shift imm in [-2048, 2047]; shifts imm in [0, 31]; beq imm in [-4096, 4094] and even; jal imm in [-1048576, 1048574] and even.
REQ-022 Unused fields (e.g. rs2 for lw, rd for sw/beq) SHALL be ignored and not appear in out_instr.
REQ-023 Single output register stage: in_ready = !out_valid || out_ready (full throughput, no combinational path from in_valid to in_ready).
REQ-024 Valid accepted request: out_instr/out_addr registered next cycle, out_valid=1, address counter += 4 (32-bit wrap).
REQ-025 Invalid accepted request (range fail or kind 6/7): no output, counter unchanged, err_pulse=1 next cycle, err_count += 1 saturating at 255.
REQ-026 While out_valid && !out_ready, out_instr and out_addr SHALL hold stable.
REQ-027 Simultaneous output drain and new accept SHALL replace the word in the same cycle with no bubble.
REQ-028 Latency: accept at cycle N -> out_valid (or err_pulse) at cycle N+1.

Reset
REQ-029 reset SHALL set out_valid=0, err_pulse=0, err_count=0, out_instr=0, out_addr=0, counter=BASE_ADDR; in-flight word discarded.
REQ-030 in_ready SHALL read 1 during and after reset; requests presented while reset=1 are dropped.

Verification
REQ-031 lw rd=5, rs1=2, imm=8 -> out_instr 0x00812283, out_addr BASE_ADDR.
REQ-032 R-type funct3=0, rd=3, rs1=1, rs2=2, funct7b5=0 then 1 -> 0x002081B3 then 0x402081B3, addrs +0, +4.
REQ-033 beq rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; jal rd=1, imm=8 -> 0x008000EF.
REQ-034 I-type addi imm=2048 -> err_pulse 1 cycle, err_count=1, no out_valid, next valid word still at previous address.
REQ-035 out_ready=0 with 2 back-to-back requests -> first word held stable, in_ready=0, second accepted only on the cycle out_ready rises.
REQ-036 reset asserted while out_valid=1 -> next cycle out_valid=0, next valid request emitted at BASE_ADDR.
